inst_fetch: RTL and testbench

Instruction fetch unit for the 16-bit CPU. It reads instruction bytes from the 8-bit memory port, assembles one- or two-byte instructions into the 16-bit word consumed by the decoder, and hands each word to the execute stage over a valid/ready handshake. It owns the program counter and accepts branch, call and return redirects from execute.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/inst_fetch.sv | 100 ++++++++++
 tb/tb_inst_fetch.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM states and instruction-format bits.
package cpu_pkg;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    // Set in the first byte when an argument byte follows (inst[15] once assembled).
    localparam int ZERO_ARG_BIT = 7;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO,
        HOLD
    } fetch_state_t;
endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles 1/2-byte instructions from an 8-bit memory port and
// hands them to execute over valid/ready; owns the PC and accepts redirects.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [BYTE_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] inst_pc,
    output logic [1:0]        inst_bytes,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] pc
);
    fetch_state_t      state;
    fetch_state_t      resume_state;
    logic              flush;
    logic [WORD_W-1:0] pc_inc;

    assign pc_inc       = pc + WORD_W'(1);
    assign resume_state = en ? FETCH_HI : IDLE;
    assign mem_req      = (state == FETCH_HI) || (state == FETCH_LO);
    assign inst_valid   = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            flush      <= 1'b0;
            mem_addr   <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_bytes <= 2'd0;
        end else if (redirect) begin
            pc <= redirect_pc;
            // An in-flight request cannot be withdrawn: keep its address and drop the byte later.
            if (mem_req && !mem_rvalid) begin
                flush <= 1'b1;
            end else begin
                flush    <= 1'b0;
                mem_addr <= redirect_pc;
                state    <= resume_state;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= FETCH_HI;
                end
                FETCH_HI: begin
                    if (mem_rvalid) begin
                        if (flush) begin
                            flush    <= 1'b0;
                            mem_addr <= pc;
                            state    <= resume_state;
                        end else begin
                            inst     <= {mem_rdata, {BYTE_W{1'b0}}};
                            inst_pc  <= pc;
                            pc       <= pc_inc;
                            mem_addr <= pc_inc;
                            if (!mem_rdata[ZERO_ARG_BIT]) begin
                                inst_bytes <= 2'd1;
                                state      <= HOLD;
                            end else begin
                                state <= FETCH_LO;
                            end
                        end
                    end
                end
                FETCH_LO: begin
                    if (mem_rvalid) begin
                        if (flush) begin
                            flush    <= 1'b0;
                            mem_addr <= pc;
                            state    <= resume_state;
                        end else begin
                            inst[BYTE_W-1:0] <= mem_rdata;
                            inst_bytes       <= 2'd2;
                            pc               <= pc_inc;
                            mem_addr         <= pc_inc;
                            state            <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) state <= resume_state;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table, directed corner sequences and a
// randomized run against an instruction-stream reference model.
module tb_inst_fetch;
    logic        clk;
    logic        rst_n = 1'b1;
    logic        en;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [1:0]  inst_bytes;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] pc;

    logic        w_req;
    logic [15:0] w_addr;
    logic [7:0]  w_rdata;
    logic [15:0] w_inst;
    logic [15:0] w_inst_pc;
    logic [1:0]  w_bytes;
    logic        w_valid;
    logic [15:0] w_pc;

    inst_fetch #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc), .inst_bytes(inst_bytes),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .pc(pc)
    );

    inst_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .mem_req(w_req), .mem_addr(w_addr),
        .mem_rdata(w_rdata), .mem_rvalid(w_req), .redirect(1'b0),
        .redirect_pc(16'h0000), .inst(w_inst), .inst_pc(w_inst_pc), .inst_bytes(w_bytes),
        .inst_valid(w_valid), .inst_ready(1'b1), .pc(w_pc)
    );

    assign w_rdata = (w_addr == 16'hFFFF) ? 8'hC0 : (w_addr == 16'h0000) ? 8'h05 : 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: configurable or random response latency, logs completed requests.
    logic [7:0]  mem [0:65535];
    int          lat_cfg = 0;
    bit          rand_lat = 1'b0;
    int          lat_rand = 0;
    int          wait_cnt;
    int          req_cnt = 0;
    logic [15:0] req_q [$];

    assign mem_rvalid = mem_req && (wait_cnt >= (rand_lat ? lat_rand : lat_cfg));
    assign mem_rdata  = mem[mem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (mem_rvalid) begin
            wait_cnt <= 0;
            lat_rand <= $urandom_range(0, 3);
            req_cnt  <= req_cnt + 1;
            req_q.push_back(mem_addr);
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int w);
        w = 0;
        while (!inst_valid && w < 60) begin
            tick();
            w++;
        end
        chk({name, "_valid_timeout"}, inst_valid, 1);
    endtask

    task automatic wait_req(input string name, input logic [15:0] addr);
        int w;
        w = 0;
        while (!(mem_req && mem_addr == addr) && w < 60) begin
            tick();
            w++;
        end
        chk({name, "_req_timeout"}, mem_req && mem_addr == addr, 1);
    endtask

    // Protocol checker and instruction-stream reference model, sampled mid-cycle.
    bit          mon_on = 1'b0;
    bit          prev_out = 1'b0;
    bit          prev_valid = 1'b0;
    logic [15:0] prev_addr;
    int          rises = 0;
    int          n_acc = 0;
    logic [15:0] model_pc;
    logic [7:0]  b0;
    logic [15:0] e_inst;
    logic [1:0]  e_bytes;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_out   = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_out) begin
                    chk("req_held", mem_req, 1);
                    chk("addr_held", mem_addr, prev_addr);
                end
                prev_out  = mem_req && !mem_rvalid;
                prev_addr = mem_addr;
                if (inst_valid && !prev_valid) rises++;
                prev_valid = inst_valid;
                if (mon_on && inst_valid && inst_ready) begin
                    b0 = mem[model_pc];
                    if (b0[7]) begin
                        e_inst  = {b0, mem[model_pc + 16'd1]};
                        e_bytes = 2'd2;
                    end else begin
                        e_inst  = {b0, 8'h00};
                        e_bytes = 2'd1;
                    end
                    chk("model_inst", inst, e_inst);
                    chk("model_inst_pc", inst_pc, model_pc);
                    chk("model_bytes", inst_bytes, e_bytes);
                    model_pc = model_pc + 16'(e_bytes);
                    n_acc++;
                end
                if (mon_on && redirect) model_pc = redirect_pc;
            end
        end
    end

    typedef struct {
        int          lat;
        int          hold;
        logic [15:0] inst;
        logic [15:0] ipc;
        logic [1:0]  bytes;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int w, r0, q0, rs;
        en = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; inst_ready = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[0] = 8'h00; mem[1] = 8'h80; mem[2] = 8'h12; mem[3] = 8'h0E;
        mem[4] = 8'h85; mem[5] = 8'hAA; mem[6] = 8'h33; mem[7] = 8'h9C;
        mem[8] = 8'h01; mem[9] = 8'h7F;
        tbl[0] = '{0, 0, 16'h0000, 16'h0000, 2'd1};
        tbl[1] = '{0, 0, 16'h8012, 16'h0001, 2'd2};
        tbl[2] = '{0, 0, 16'h0E00, 16'h0003, 2'd1};
        tbl[3] = '{3, 0, 16'h85AA, 16'h0004, 2'd2};
        tbl[4] = '{3, 0, 16'h3300, 16'h0006, 2'd1};
        tbl[5] = '{1, 5, 16'h9C01, 16'h0007, 2'd2};
        tbl[6] = '{2, 0, 16'h7F00, 16'h0009, 2'd1};

        #1 rst_n = 1'b0;
        #3;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_wrap_pc", w_pc, 16'hFFFF);
        chk("rst_wrap_addr", w_addr, 16'hFFFF);
        tick(); tick();
        rst_n = 1'b1;

        // Two-byte instruction straddling the top of the address space.
        w = 0;
        while (!w_valid && w < 20) begin tick(); w++; end
        chk("wrap_valid_timeout", w_valid, 1);
        chk("wrap_inst", w_inst, 16'hC005);
        chk("wrap_bytes", w_bytes, 2'd2);
        chk("wrap_inst_pc", w_inst_pc, 16'hFFFF);
        tick();
        chk("wrap_next_req", w_req, 1);
        chk("wrap_next_addr", w_addr, 16'h0001);

        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            lat_cfg    = tbl[i].lat;
            inst_ready = (tbl[i].hold == 0);
            r0 = req_cnt;
            rs = rises;
            wait_valid($sformatf("vec%0d", i), w);
            if (i > 0 && tbl[i].lat == 0) chk($sformatf("vec%0d_latency", i), w, 32'(tbl[i].bytes));
            chk($sformatf("vec%0d_inst", i), inst, tbl[i].inst);
            chk($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].ipc);
            chk($sformatf("vec%0d_bytes", i), inst_bytes, tbl[i].bytes);
            for (int h = 0; h < tbl[i].hold; h++) begin
                tick();
                chk($sformatf("vec%0d_hold_inst", i), inst, tbl[i].inst);
                chk($sformatf("vec%0d_hold_pc", i), inst_pc, tbl[i].ipc);
                chk($sformatf("vec%0d_hold_req", i), mem_req, 0);
                chk($sformatf("vec%0d_hold_valid", i), inst_valid, 1);
            end
            inst_ready = 1'b1;
            tick();
            chk($sformatf("vec%0d_reqs", i), req_cnt - r0, 32'(tbl[i].bytes));
            chk($sformatf("vec%0d_rises", i), rises - rs, 1);
        end

        // Redirect while the second-byte request is outstanding.
        mem[10] = 8'h90; mem[11] = 8'h22; mem[16'h40] = 8'h05; mem[16'h41] = 8'hA0;
        mem[16'h42] = 8'h5A;
        lat_cfg = 5;
        wait_req("redir", 16'd11);
        req_q.delete();
        rs = rises;
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("redir_pc", pc, 16'h0040);
        chk("redir_addr_old", mem_addr, 16'd11);
        chk("redir_req_kept", mem_req, 1);
        chk("redir_no_valid", inst_valid, 0);
        wait_valid("redir", w);
        chk("redir_inst", inst, 16'h0500);
        chk("redir_inst_pc", inst_pc, 16'h0040);
        q0 = req_q.size();
        chk("redir_req_count", q0, 2);
        if (q0 == 2) begin
            chk("redir_req0", req_q[0], 16'd11);
            chk("redir_req1", req_q[1], 16'h0040);
        end
        tick();
        chk("redir_rises", rises - rs, 1);

        // en dropped mid-instruction, then asynchronous reset during a wait.
        lat_cfg = 4;
        inst_ready = 1'b0;
        wait_req("en_low", 16'h0042);
        en = 1'b0;
        wait_valid("en_low", w);
        chk("en_low_inst", inst, 16'hA05A);
        chk("en_low_inst_pc", inst_pc, 16'h0041);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_req", mem_req, 0);
            chk("idle_valid", inst_valid, 0);
        end
        lat_cfg = 10;
        en = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_addr", mem_addr, 16'h0000);
        chk("async_rst_pc", pc, 16'h0000);
        chk("async_rst_inst", inst, 16'h0000);
        chk("async_rst_inst_pc", inst_pc, 16'h0000);
        chk("async_rst_bytes", inst_bytes, 2'd0);
        chk("async_rst_valid", inst_valid, 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;

        // Randomized run against the instruction-stream model.
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        rand_lat = 1'b1;
        model_pc = 16'h0000;
        mon_on = 1'b1;
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom);
            tick();
        end
        redirect = 1'b0;
        @(negedge clk);
        mon_on = 1'b0;
        chk("rand_progress", n_acc > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
